// File: rtl/lvds_train_ctrl.sv
// Link-training sequencer for a group of lvds_rx lanes sharing one clkdiv domain.
// Drives lane reset and alignment enables, verifies the training word and retries on failure.
module lvds_train_ctrl #(
  parameter  int LANES         = 4,
  parameter  int DATA_WIDTH    = 10,
  parameter  int RST_CYCLES    = 16,
  parameter  int ALIGN_TIMEOUT = 4096,
  parameter  int VERIFY_CYCLES = 256,
  parameter  int MAX_RETRY     = 3,
  localparam int RETRY_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        idelayCtrl_rdy,
  input  logic [DATA_WIDTH-1:0]       pattern,
  input  logic [LANES*DATA_WIDTH-1:0] lane_tdata,
  input  logic [LANES-1:0]            bitslip_done,
  output logic                        lane_reset,
  output logic                        bit_align_en,
  output logic                        bitslip_en,
  output logic [LANES-1:0]            lane_ok,
  output logic                        train_done,
  output logic                        train_fail,
  output logic [RETRY_W-1:0]          retry_cnt,
  output logic [2:0]                  state_dbg
);

  localparam int CNT_MAX_A = (RST_CYCLES > ALIGN_TIMEOUT) ? RST_CYCLES : ALIGN_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > VERIFY_CYCLES) ? CNT_MAX_A : VERIFY_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    LANE_RST = 3'd2,
    ALIGN    = 3'd3,
    VERIFY   = 3'd4,
    LOCKED   = 3'd5,
    FAIL     = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [RETRY_W-1:0]   retry_nxt;
  logic                 retry_req;
  logic                 all_done;
  logic                 past_wait_rdy;
  logic                 lane_reset_nxt;
  logic                 align_en_nxt;
  logic                 done_nxt;
  logic                 fail_nxt;
  logic [LANES-1:0]     lane_ok_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign all_done      = &bitslip_done;
  assign past_wait_rdy = (state == LANE_RST) || (state == ALIGN) ||
                         (state == VERIFY)   || (state == LOCKED);

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      retry_cnt    <= '0;
      lane_reset   <= 1'b1;
      bit_align_en <= 1'b0;
      bitslip_en   <= 1'b0;
      lane_ok      <= '0;
      train_done   <= 1'b0;
      train_fail   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry_cnt    <= retry_nxt;
      lane_reset   <= lane_reset_nxt;
      bit_align_en <= align_en_nxt;
      bitslip_en   <= align_en_nxt;
      lane_ok      <= lane_ok_nxt;
      train_done   <= done_nxt;
      train_fail   <= fail_nxt;
    end
  end

  assign state_dbg = state;

  // Next-state: start beats loss of IDELAYCTRL ready, which beats normal sequencing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    retry_req = 1'b0;
    if (start) begin
      state_nxt = WAIT_RDY;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else if (!idelayCtrl_rdy && past_wait_rdy) begin
      state_nxt = WAIT_RDY;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: ;
        WAIT_RDY: begin
          if (idelayCtrl_rdy) begin
            state_nxt = LANE_RST;
            cnt_nxt   = '0;
          end
        end
        LANE_RST: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state_nxt = ALIGN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        ALIGN: begin
          if (all_done) begin
            state_nxt = VERIFY;
            cnt_nxt   = '0;
          end else if (cnt == CNT_W'(ALIGN_TIMEOUT - 1)) begin
            retry_req = 1'b1;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        VERIFY: begin
          // lane_ok lags the data by one cycle, so the run length is counted on the registered match
          if (!all_done) begin
            retry_req = 1'b1;
          end else if (cnt >= CNT_W'(VERIFY_CYCLES)) begin
            state_nxt = LOCKED;
            cnt_nxt   = '0;
          end else if (&lane_ok) begin
            cnt_nxt = sat_inc(cnt);
          end else begin
            cnt_nxt = '0;
          end
        end
        LOCKED: ;
        FAIL: ;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
      if (retry_req) begin
        cnt_nxt = '0;
        if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
          state_nxt = FAIL;
        end else begin
          retry_nxt = retry_cnt + 1'b1;
          state_nxt = LANE_RST;
        end
      end
    end
  end

  // Outputs decoded from the next state so every output is a flop aligned with state
  always_comb begin
    lane_reset_nxt = 1'b1;
    align_en_nxt   = 1'b0;
    done_nxt       = 1'b0;
    fail_nxt       = 1'b0;
    case (state_nxt)
      ALIGN, VERIFY: begin
        lane_reset_nxt = 1'b0;
        align_en_nxt   = 1'b1;
      end
      LOCKED: begin
        lane_reset_nxt = 1'b0;
        align_en_nxt   = 1'b1;
        done_nxt       = 1'b1;
      end
      FAIL: fail_nxt = 1'b1;
      default: ;
    endcase
    lane_ok_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((state_nxt == VERIFY) || (state_nxt == LOCKED)) begin
        lane_ok_nxt[i] = (lane_tdata[i*DATA_WIDTH +: DATA_WIDTH] == pattern);
      end
    end
  end

endmodule

// File: tb/tb_lvds_train_ctrl.sv
// Directed bench for lvds_train_ctrl: timed expectations are queued by the stimulus
// and compared by an independent negedge monitor.
module tb_lvds_train_ctrl;
  localparam int LANES = 4;
  localparam int DW    = 10;

  localparam int S_ST    = 0;
  localparam int S_LRST  = 1;
  localparam int S_BAE   = 2;
  localparam int S_BSE   = 3;
  localparam int S_LOK   = 4;
  localparam int S_DONE  = 5;
  localparam int S_FAIL  = 6;
  localparam int S_RETRY = 7;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  rdy = 1'b1;
  logic [DW-1:0]         pattern = 10'h3F0;
  logic [LANES*DW-1:0]   corrupt = '0;
  logic [LANES*DW-1:0]   lane_tdata;
  logic [LANES-1:0]      bitslip_done = '0;
  logic                  lane_reset, bit_align_en, bitslip_en, train_done, train_fail;
  logic [LANES-1:0]      lane_ok;
  logic [1:0]            retry_cnt;
  logic [2:0]            state_dbg;

  assign lane_tdata = {LANES{pattern}} ^ corrupt;

  lvds_train_ctrl #(
    .LANES(LANES), .DATA_WIDTH(DW), .RST_CYCLES(16), .ALIGN_TIMEOUT(4096),
    .VERIFY_CYCLES(256), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .idelayCtrl_rdy(rdy), .pattern(pattern),
    .lane_tdata(lane_tdata), .bitslip_done(bitslip_done), .lane_reset(lane_reset),
    .bit_align_en(bit_align_en), .bitslip_en(bitslip_en), .lane_ok(lane_ok),
    .train_done(train_done), .train_fail(train_fail), .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    int          sel;
    int unsigned expv;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned dut_val(input int sel);
    case (sel)
      S_ST:    return {29'd0, state_dbg};
      S_LRST:  return {31'd0, lane_reset};
      S_BAE:   return {31'd0, bit_align_en};
      S_BSE:   return {31'd0, bitslip_en};
      S_LOK:   return {28'd0, lane_ok};
      S_DONE:  return {31'd0, train_done};
      S_FAIL:  return {31'd0, train_fail};
      default: return {30'd0, retry_cnt};
    endcase
  endfunction

  task automatic push_exp(input int off, input int sel, input int unsigned v, input string name);
    exp_t e;
    e.due  = cyc + off;
    e.sel  = sel;
    e.expv = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that has come due, away from the active edge
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        int unsigned act;
        act = dut_val(sb[i].sel);
        n_chk++;
        if (sb[i].due < cyc)
          $display("FAIL %s: overdue at cycle %0d (due %0d)", sb[i].name, cyc, sb[i].due);
        else if (act == sb[i].expv)
          n_pass++;
        else
          $display("FAIL %s: got %0h expected %0h at cycle %0d", sb[i].name, act, sb[i].expv, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    // reset values
    tick(2);
    push_exp(0, S_ST, 0, "rst_state");
    push_exp(0, S_LRST, 1, "rst_lane_reset");
    push_exp(0, S_BAE, 0, "rst_align_en");
    push_exp(0, S_LOK, 0, "rst_lane_ok");
    push_exp(0, S_DONE, 0, "rst_done");
    push_exp(0, S_RETRY, 0, "rst_retry");
    tick(1);
    reset = 1'b1;
    tick(2);

    // nominal training, bitslip_done 50 cycles into ALIGN
    bitslip_done = '0;
    start = 1'b1;
    push_exp(1, S_ST, 1, "nom_wait_rdy");
    push_exp(2, S_ST, 2, "nom_lane_rst");
    push_exp(2, S_LRST, 1, "nom_lrst_hi");
    push_exp(17, S_ST, 2, "nom_lrst_last");
    push_exp(18, S_ST, 3, "nom_align");
    push_exp(18, S_LRST, 0, "nom_lrst_lo");
    push_exp(18, S_BAE, 1, "nom_align_en");
    push_exp(18, S_BSE, 1, "nom_bitslip_en");
    push_exp(68, S_ST, 3, "nom_align_end");
    push_exp(69, S_ST, 4, "nom_verify");
    push_exp(325, S_ST, 4, "nom_verify_last");
    push_exp(326, S_ST, 5, "nom_locked");
    push_exp(326, S_DONE, 1, "nom_done");
    push_exp(326, S_RETRY, 0, "nom_retry");
    push_exp(326, S_LOK, 15, "nom_lane_ok");
    tick(1);
    start = 1'b0;
    tick(67);
    bitslip_done = 4'hF;
    tick(260);

    // alignment timeout: lane 2 never done
    bitslip_done = 4'b1011;
    start = 1'b1;
    push_exp(1, S_ST, 1, "to_restart");
    push_exp(1, S_DONE, 0, "to_done_clr");
    push_exp(4113, S_ST, 3, "to_align_last");
    push_exp(4113, S_BAE, 1, "to_en_decision");
    push_exp(4114, S_ST, 2, "to_retry1_lrst");
    push_exp(4114, S_RETRY, 1, "to_retry1");
    push_exp(4114, S_LRST, 1, "to_lrst_hi");
    push_exp(4114, S_BSE, 0, "to_en_drop");
    push_exp(4129, S_ST, 2, "to_lrst_last");
    push_exp(4130, S_ST, 3, "to_align2");
    push_exp(4130, S_LRST, 0, "to_lrst_lo");
    push_exp(16449, S_ST, 3, "to_align4_last");
    push_exp(16449, S_RETRY, 3, "to_retry3");
    push_exp(16450, S_ST, 6, "to_fail");
    push_exp(16450, S_FAIL, 1, "to_fail_flag");
    push_exp(16450, S_RETRY, 3, "to_fail_retry");
    push_exp(16450, S_LRST, 1, "to_fail_lrst");
    push_exp(16460, S_ST, 6, "to_fail_sticky");
    tick(1);
    start = 1'b0;
    tick(16465);

    // start clears FAIL; single glitch on lane 1 at VERIFY cycle 200
    bitslip_done = '0;
    start = 1'b1;
    push_exp(1, S_FAIL, 0, "gl_fail_clr");
    push_exp(1, S_ST, 1, "gl_restart");
    push_exp(1, S_RETRY, 0, "gl_retry_clr");
    push_exp(19, S_ST, 4, "gl_verify");
    push_exp(219, S_LOK, 15, "gl_lok_pre");
    push_exp(220, S_LOK, 4'b1101, "gl_lok_glitch");
    push_exp(276, S_ST, 4, "gl_no_early_lock");
    push_exp(477, S_ST, 4, "gl_verify_last");
    push_exp(478, S_ST, 5, "gl_locked");
    push_exp(478, S_RETRY, 0, "gl_no_retry");
    tick(1);
    start = 1'b0;
    tick(17);
    bitslip_done = 4'hF;
    tick(201);
    corrupt[DW +: DW] = 10'h001;
    tick(1);
    corrupt = '0;
    tick(260);

    // lane 1 held wrong: never locks; then bitslip_done drop forces a retry
    corrupt[DW +: DW] = 10'h001;
    start = 1'b1;
    push_exp(1, S_ST, 1, "hw_restart");
    push_exp(19, S_ST, 4, "hw_verify");
    push_exp(320, S_ST, 4, "hw_no_lock");
    push_exp(320, S_LOK, 4'b1101, "hw_lok");
    push_exp(320, S_RETRY, 0, "hw_retry0");
    tick(1);
    start = 1'b0;
    tick(320);
    bitslip_done = 4'b1110;
    push_exp(1, S_ST, 2, "bd_lane_rst");
    push_exp(1, S_RETRY, 1, "bd_retry1");
    push_exp(1, S_BAE, 0, "bd_en_drop");
    push_exp(1, S_LRST, 1, "bd_lrst");
    push_exp(274, S_ST, 4, "bd_verify_last");
    push_exp(275, S_ST, 5, "bd_locked");
    push_exp(275, S_RETRY, 1, "bd_locked_retry");
    tick(1);
    bitslip_done = 4'hF;
    corrupt = '0;
    tick(279);

    // IDELAYCTRL ready lost for 10 cycles while locked
    rdy = 1'b0;
    push_exp(1, S_ST, 1, "rl_wait_rdy");
    push_exp(1, S_DONE, 0, "rl_done_clr");
    push_exp(1, S_LRST, 1, "rl_lrst");
    push_exp(1, S_RETRY, 1, "rl_retry_kept");
    push_exp(1, S_BSE, 0, "rl_en_drop");
    push_exp(10, S_ST, 1, "rl_still_wait");
    push_exp(11, S_ST, 2, "rl_lane_rst");
    push_exp(27, S_ST, 3, "rl_align");
    push_exp(28, S_ST, 4, "rl_verify");
    push_exp(285, S_ST, 5, "rl_relock");
    push_exp(285, S_RETRY, 1, "rl_relock_retry");
    push_exp(285, S_DONE, 1, "rl_relock_done");
    tick(10);
    rdy = 1'b1;
    tick(280);

    // reach ALIGN with retry_cnt=1, then start and rdy loss together
    bitslip_done = '0;
    rdy = 1'b0;
    push_exp(18, S_ST, 3, "sim_in_align");
    push_exp(18, S_RETRY, 1, "sim_retry_pre");
    tick(1);
    rdy = 1'b1;
    tick(19);
    start = 1'b1;
    rdy = 1'b0;
    push_exp(1, S_ST, 1, "sim_wait_rdy");
    push_exp(1, S_RETRY, 0, "sim_start_wins");
    push_exp(9, S_ST, 1, "sim_held_wait");
    push_exp(10, S_ST, 2, "sim_lane_rst");
    push_exp(27, S_ST, 4, "sim_verify");
    tick(1);
    start = 1'b0;
    tick(8);
    rdy = 1'b1;
    bitslip_done = 4'hF;
    tick(60);

    // asynchronous reset mid-VERIFY, off the clock edge
    #2;
    push_exp(0, S_ST, 0, "ar_state");
    push_exp(0, S_LRST, 1, "ar_lrst");
    push_exp(0, S_BAE, 0, "ar_align_en");
    push_exp(0, S_BSE, 0, "ar_bitslip_en");
    push_exp(0, S_LOK, 0, "ar_lane_ok");
    push_exp(0, S_DONE, 0, "ar_done");
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    push_exp(20, S_ST, 0, "ar_idle_hold");
    push_exp(20, S_LRST, 1, "ar_idle_lrst");
    tick(21);
    start = 1'b1;
    push_exp(1, S_ST, 1, "ar_start_again");
    tick(1);
    start = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
